// File: rtl/img_timing_pkg.sv
// Shared types and constants for the img_timing_gen video timing generator.
package img_timing_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   // Colour-bar order left to right: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [23:0] BAR_RGB [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic int calc_total(input int sync_w, input int bp_w,
                                     input int active_w, input int fp_w);
      return sync_w + bp_w + active_w + fp_w;
   endfunction

endpackage

// File: rtl/img_timing_gen.sv
// Parametrised video timing generator with run/stop control and pixel clock-enable.
// Optional colour-bar output pat_data is built when IMG_TIMING_PATTERN_EN is defined.
module img_timing_gen
   import img_timing_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CNT_W    = 12,
   parameter int FCNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              run,
   output logic              vs,
   output logic              hs,
   output logic              de,
   output logic [CNT_W-1:0]  x,
   output logic [CNT_W-1:0]  y,
   output logic              line_start,
   output logic              frame_start,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              busy
`ifdef IMG_TIMING_PATTERN_EN
   ,
   output logic [23:0]       pat_data
`endif
);

   localparam int H_TOTAL = calc_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL = calc_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_DE_FIRST = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] H_DE_LAST  = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] V_DE_FIRST = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] V_DE_LAST  = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
   logic             frame_end;

   logic             hs_p0, vs_p0, de_p0, ls_p0, fs_p0;
   logic [CNT_W-1:0] x_p0, y_p0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (ce) begin
         state <= state_nxt;
         h_cnt <= h_nxt;
         v_cnt <= v_nxt;
      end
   end

   // A stop request only takes effect on the last pixel, so frames are never truncated.
   always_comb begin
      state_nxt = state;
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      frame_end = (state != IDLE) && (h_cnt == H_LAST) && (v_cnt == V_LAST);
      case (state)
         IDLE: begin
            h_nxt = '0;
            v_nxt = '0;
            if (run) state_nxt = ACTIVE;
         end
         ACTIVE, DRAIN: begin
            if (h_cnt == H_LAST) begin
               h_nxt = '0;
               v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
               h_nxt = h_cnt + CNT_W'(1);
            end
            if (run)            state_nxt = ACTIVE;
            else if (frame_end) state_nxt = IDLE;
            else                state_nxt = DRAIN;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: decode from the current counter values
   always_comb begin
      hs_p0 = (h_cnt < H_SYNC_END);
      vs_p0 = (v_cnt < V_SYNC_END);
      de_p0 = (h_cnt >= H_DE_FIRST) && (h_cnt <= H_DE_LAST) &&
              (v_cnt >= V_DE_FIRST) && (v_cnt <= V_DE_LAST);
      x_p0  = h_cnt - H_DE_FIRST;
      y_p0  = v_cnt - V_DE_FIRST;
      ls_p0 = de_p0 && (h_cnt == H_DE_FIRST);
      fs_p0 = ls_p0 && (v_cnt == V_DE_FIRST);
   end

   // Output registers: one ce-cycle behind the counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs          <= ~VS_POL;
         hs          <= ~HS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
         busy        <= 1'b0;
      end else if (ce) begin
         if (state == IDLE) begin
            vs          <= ~VS_POL;
            hs          <= ~HS_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
         end else begin
            vs          <= vs_p0 ? VS_POL : ~VS_POL;
            hs          <= hs_p0 ? HS_POL : ~HS_POL;
            de          <= de_p0;
            x           <= x_p0;
            y           <= y_p0;
            line_start  <= ls_p0;
            frame_start <= fs_p0;
            busy        <= 1'b1;
         end
         if (frame_end) frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

`ifdef IMG_TIMING_PATTERN_EN
   function automatic logic [23:0] bar_color(input logic [CNT_W-1:0] xa);
      int band;
      band = (int'(xa) * 8) / H_ACTIVE;
      return BAR_RGB[band[2:0]];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_data <= '0;
      end else if (ce) begin
         pat_data <= ((state != IDLE) && de_p0) ? bar_color(x_p0) : 24'h000000;
      end
   end
`endif

endmodule
